// File: rtl/phy_mgmt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phy_mgmt_sequencer
// Brief    : PHY reset/settle, per-port init write and round-robin BMSR link
//            polling for four RGMII PHYs behind one shared MDIO engine.
// Revision : 1.0 - initial release
// ============================================================================
module phy_mgmt_sequencer #(
    parameter int unsigned RST_CYCLES    = 1250000,
    parameter int unsigned SETTLE_CYCLES = 625000,
    parameter int unsigned POLL_CYCLES   = 12500000,
    parameter int unsigned RSP_TIMEOUT   = 65535,
    parameter logic [4:0]  PHY_ADDR_BASE = 5'd0,
    parameter logic [4:0]  INIT_REG      = 5'd20,
    parameter logic [15:0] INIT_DATA     = 16'h0CE2
) (
    input  logic        bd_fclk0_125m,
    input  logic        bd_rst,
    input  logic        sw_rst_req,
    output logic        phy_rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [4:0]  cmd_phyad,
    output logic [4:0]  cmd_regad,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic [3:0]  link_up,
    output logic        init_done,
    output logic        timeout_err
);

    localparam int unsigned c_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned c_MAX_B = (POLL_CYCLES > RSP_TIMEOUT) ? POLL_CYCLES : RSP_TIMEOUT;
    localparam int unsigned c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int unsigned c_TW    = $clog2(c_MAX + 1);

    // Timer holds "cycles remaining minus one"; a state exits when it reads zero.
    localparam logic [c_TW-1:0] c_LD_RST    = c_TW'(RST_CYCLES - 1);
    localparam logic [c_TW-1:0] c_LD_SETTLE = c_TW'(SETTLE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_LD_POLL   = c_TW'(POLL_CYCLES - 1);
    localparam logic [c_TW-1:0] c_LD_RSP    = c_TW'(RSP_TIMEOUT - 1);
    localparam logic [4:0]      c_REG_BMSR  = 5'd1;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_INIT_REQ  = 3'd2,
        ST_INIT_WAIT = 3'd3,
        ST_POLL_IDLE = 3'd4,
        ST_POLL_REQ  = 3'd5,
        ST_POLL_WAIT = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_TW-1:0] r_tmr, w_tmr_nxt;
    logic [1:0]      r_port, w_port_nxt;

    logic        w_phy_rst_n_nxt, w_cmd_valid_nxt, w_cmd_write_nxt;
    logic [4:0]  w_cmd_phyad_nxt, w_cmd_regad_nxt;
    logic [15:0] w_cmd_wdata_nxt;
    logic [3:0]  w_link_up_nxt;
    logic        w_init_done_nxt, w_timeout_err_nxt;
    logic        w_issue_init, w_issue_poll, w_rsp_done, w_tmr_zero;

    // Only BMSR link-status bit 2 is consumed.
    logic w_unused_rdata;
    assign w_unused_rdata = ^{rsp_rdata[15:3], rsp_rdata[1:0]};

    assign w_tmr_zero = (r_tmr == '0);
    assign w_rsp_done = rsp_valid || w_tmr_zero;

    always_comb begin
        w_state_nxt       = r_state;
        w_tmr_nxt         = r_tmr;
        w_port_nxt        = r_port;
        w_phy_rst_n_nxt   = phy_rst_n;
        w_cmd_valid_nxt   = cmd_valid;
        w_cmd_write_nxt   = cmd_write;
        w_cmd_phyad_nxt   = cmd_phyad;
        w_cmd_regad_nxt   = cmd_regad;
        w_cmd_wdata_nxt   = cmd_wdata;
        w_link_up_nxt     = link_up;
        w_init_done_nxt   = init_done;
        w_timeout_err_nxt = timeout_err;
        w_issue_init      = 1'b0;
        w_issue_poll      = 1'b0;

        case (r_state)
            ST_RST_HOLD: begin
                w_phy_rst_n_nxt = 1'b0;
                if (w_tmr_zero) begin
                    w_state_nxt     = ST_SETTLE;
                    w_tmr_nxt       = c_LD_SETTLE;
                    w_phy_rst_n_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - c_TW'(1);
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_port_nxt   = 2'd0;
                    w_issue_init = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - c_TW'(1);
                end
            end
            ST_INIT_REQ, ST_POLL_REQ: begin
                if (cmd_valid && cmd_ready) begin
                    w_state_nxt     = (r_state == ST_INIT_REQ) ? ST_INIT_WAIT : ST_POLL_WAIT;
                    w_tmr_nxt       = c_LD_RSP;
                    w_cmd_valid_nxt = 1'b0;
                end
            end
            ST_INIT_WAIT: begin
                if (w_rsp_done) begin
                    if (!rsp_valid) begin
                        w_timeout_err_nxt = 1'b1;
                    end
                    if (r_port == 2'd3) begin
                        w_state_nxt     = ST_POLL_IDLE;
                        w_tmr_nxt       = c_LD_POLL;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_port_nxt   = r_port + 2'd1;
                        w_issue_init = 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - c_TW'(1);
                end
            end
            ST_POLL_IDLE: begin
                if (w_tmr_zero) begin
                    w_port_nxt   = 2'd0;
                    w_issue_poll = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - c_TW'(1);
                end
            end
            ST_POLL_WAIT: begin
                if (w_rsp_done) begin
                    if (rsp_valid) begin
                        w_link_up_nxt[r_port] = rsp_rdata[2];
                    end else begin
                        w_link_up_nxt[r_port] = 1'b0;
                        w_timeout_err_nxt     = 1'b1;
                    end
                    if (r_port == 2'd3) begin
                        w_state_nxt = ST_POLL_IDLE;
                        w_tmr_nxt   = c_LD_POLL;
                    end else begin
                        w_port_nxt   = r_port + 2'd1;
                        w_issue_poll = 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - c_TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RST_HOLD;
                w_tmr_nxt   = c_LD_RST;
            end
        endcase

        if (w_issue_init) begin
            w_state_nxt     = ST_INIT_REQ;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_write_nxt = 1'b1;
            w_cmd_phyad_nxt = PHY_ADDR_BASE + {3'b000, w_port_nxt};
            w_cmd_regad_nxt = INIT_REG;
            w_cmd_wdata_nxt = INIT_DATA;
        end
        if (w_issue_poll) begin
            w_state_nxt     = ST_POLL_REQ;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_write_nxt = 1'b0;
            w_cmd_phyad_nxt = PHY_ADDR_BASE + {3'b000, w_port_nxt};
            w_cmd_regad_nxt = c_REG_BMSR;
            w_cmd_wdata_nxt = 16'h0000;
        end

        // Software restart wins over everything but keeps the sticky error.
        if (sw_rst_req) begin
            w_state_nxt     = ST_RST_HOLD;
            w_tmr_nxt       = c_LD_RST;
            w_phy_rst_n_nxt = 1'b0;
            w_cmd_valid_nxt = 1'b0;
            w_link_up_nxt   = 4'b0000;
            w_init_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge bd_fclk0_125m) begin
        if (bd_rst) begin
            r_state     <= ST_RST_HOLD;
            r_tmr       <= c_LD_RST;
            r_port      <= 2'd0;
            phy_rst_n   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_phyad   <= 5'd0;
            cmd_regad   <= 5'd0;
            cmd_wdata   <= 16'h0000;
            link_up     <= 4'b0000;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_port      <= w_port_nxt;
            phy_rst_n   <= w_phy_rst_n_nxt;
            cmd_valid   <= w_cmd_valid_nxt;
            cmd_write   <= w_cmd_write_nxt;
            cmd_phyad   <= w_cmd_phyad_nxt;
            cmd_regad   <= w_cmd_regad_nxt;
            cmd_wdata   <= w_cmd_wdata_nxt;
            link_up     <= w_link_up_nxt;
            init_done   <= w_init_done_nxt;
            timeout_err <= w_timeout_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_mgmt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_mgmt_sequencer
// Brief    : Directed self-checking bench for phy_mgmt_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_mgmt_sequencer;

    logic        bd_fclk0_125m = 1'b0;
    logic        bd_rst;
    logic        sw_rst_req;
    logic        phy_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [3:0]  link_up;
    logic        init_done;
    logic        timeout_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_acc   = 0;

    always #4 bd_fclk0_125m = ~bd_fclk0_125m;

    phy_mgmt_sequencer #(
        .RST_CYCLES    (8),
        .SETTLE_CYCLES (4),
        .POLL_CYCLES   (16),
        .RSP_TIMEOUT   (32),
        .PHY_ADDR_BASE (5'd4),
        .INIT_REG      (5'd20),
        .INIT_DATA     (16'h0CE2)
    ) u_dut (
        .bd_fclk0_125m (bd_fclk0_125m),
        .bd_rst        (bd_rst),
        .sw_rst_req    (sw_rst_req),
        .phy_rst_n     (phy_rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_phyad     (cmd_phyad),
        .cmd_regad     (cmd_regad),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .link_up       (link_up),
        .init_done     (init_done),
        .timeout_err   (timeout_err)
    );

    always @(posedge bd_fclk0_125m) begin
        if (!bd_rst && cmd_valid && cmd_ready) n_acc <= n_acc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedge samples (including the current one) until cmd_valid is seen.
    task automatic count_idle(output int cnt);
        cnt = 0;
        while (cmd_valid !== 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge bd_fclk0_125m);
        end
    endtask

    // Entered at a negedge with the command visible; responds 3 cycles after accept.
    task automatic serve(input string tag, input logic wr, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] rd);
        check_eq($sformatf("%s_cmd", tag),
                 32'({cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata}),
                 32'({1'b1, wr, pa, ra, wd}));
        @(negedge bd_fclk0_125m);
        check_eq($sformatf("%s_drop", tag), 32'(cmd_valid), 32'd0);
        repeat (2) @(negedge bd_fclk0_125m);
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        @(negedge bd_fclk0_125m);
        rsp_valid = 1'b0;
        rsp_rdata = 16'h0000;
    endtask

    task automatic init_round();
        int cnt;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                count_idle(cnt);
                check_eq("init_gap", 32'(cnt), 32'd0);
            end
            serve($sformatf("init%0d", i), 1'b1, 5'(4 + i), 5'd20, 16'h0CE2, 16'h0000);
            if (i < 3) check_eq("init_done_early", 32'(init_done), 32'd0);
        end
        check_eq("init_done", 32'(init_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int acc0;
        logic [15:0] rd1 [4];
        logic [15:0] rd4 [4];
        rd1 = '{16'h0004, 16'h0000, 16'h0004, 16'h0004};
        rd4 = '{16'h0000, 16'h0004, 16'h0000, 16'h0000};

        bd_rst     = 1'b1;
        sw_rst_req = 1'b0;
        cmd_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_rdata  = 16'h0000;
        repeat (3) @(posedge bd_fclk0_125m);
        @(negedge bd_fclk0_125m);

        check_eq("rst_outputs",
                 32'({phy_rst_n, cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata}),
                 32'd0);
        check_eq("rst_status", 32'({link_up, init_done, timeout_err}), 32'd0);

        bd_rst = 1'b0;
        cnt = 0;
        while (phy_rst_n === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge bd_fclk0_125m);
        end
        check_eq("rst_hold_len", 32'(cnt), 32'd8);
        count_idle(cnt);
        check_eq("settle_len", 32'(cnt), 32'd4);

        init_round();
        count_idle(cnt);
        check_eq("idle_after_init", 32'(cnt), 32'd16);

        // Poll round 1: ports 0..3 report link 1,0,1,1.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                count_idle(cnt);
                check_eq("poll1_gap", 32'(cnt), 32'd0);
            end
            serve($sformatf("poll1_%0d", i), 1'b0, 5'(4 + i), 5'd1, 16'h0000, rd1[i]);
            if (i == 0) check_eq("link0_update", 32'(link_up[0]), 32'd1);
        end
        check_eq("link_round1", 32'(link_up), 32'hD);
        count_idle(cnt);
        check_eq("idle_round1", 32'(cnt), 32'd16);

        // Round 2, port 0: engine stalls for 10 cycles.
        cmd_ready = 1'b0;
        acc0 = n_acc;
        repeat (10) begin
            @(negedge bd_fclk0_125m);
            check_eq("stall_hold",
                     32'({cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata}),
                     32'({1'b1, 1'b0, 5'd4, 5'd1, 16'h0000}));
        end
        check_eq("stall_no_accept", 32'(n_acc - acc0), 32'd0);
        cmd_ready = 1'b1;
        serve("poll2_0", 1'b0, 5'd4, 5'd1, 16'h0000, 16'h0004);
        check_eq("stall_one_accept", 32'(n_acc - acc0), 32'd1);
        count_idle(cnt);
        check_eq("poll2_gap", 32'(cnt), 32'd0);
        serve("poll2_1", 1'b0, 5'd5, 5'd1, 16'h0000, 16'h0004);
        check_eq("link_all_up", 32'(link_up), 32'hF);

        // Round 2, port 2: no response, expect timeout after 32 wait cycles.
        count_idle(cnt);
        check_eq("to_cmd", 32'({cmd_valid, cmd_phyad, cmd_regad}), 32'({1'b1, 5'd6, 5'd1}));
        @(negedge bd_fclk0_125m);
        check_eq("to_drop", 32'(cmd_valid), 32'd0);
        repeat (31) @(negedge bd_fclk0_125m);
        check_eq("to_not_yet", 32'({timeout_err, link_up}), 32'({1'b0, 4'hF}));
        @(negedge bd_fclk0_125m);
        check_eq("to_err_set", 32'(timeout_err), 32'd1);
        check_eq("to_link_clr", 32'(link_up), 32'hB);
        check_eq("to_next_port", 32'({cmd_valid, cmd_phyad}), 32'({1'b1, 5'd7}));
        serve("poll2_3", 1'b0, 5'd7, 5'd1, 16'h0000, 16'h0004);
        check_eq("link_round2", 32'(link_up), 32'hB);
        count_idle(cnt);
        check_eq("idle_round2", 32'(cnt), 32'd16);

        // Round 3: bring all links up, then restart while port 3 is outstanding.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                count_idle(cnt);
                check_eq("poll3_gap", 32'(cnt), 32'd0);
            end
            serve($sformatf("poll3_%0d", i), 1'b0, 5'(4 + i), 5'd1, 16'h0000, 16'h0004);
        end
        check_eq("link_before_swrst", 32'(link_up), 32'hF);
        count_idle(cnt);
        check_eq("swrst_cmd", 32'({cmd_valid, cmd_phyad}), 32'({1'b1, 5'd7}));
        @(negedge bd_fclk0_125m);
        sw_rst_req = 1'b1;
        @(negedge bd_fclk0_125m);
        sw_rst_req = 1'b0;
        check_eq("swrst_clear",
                 32'({link_up, init_done, cmd_valid, phy_rst_n}), 32'd0);
        check_eq("swrst_keep_err", 32'(timeout_err), 32'd1);
        rsp_valid = 1'b1;
        rsp_rdata = 16'h0004;
        cnt = 1;
        @(negedge bd_fclk0_125m);
        rsp_valid = 1'b0;
        rsp_rdata = 16'h0000;
        check_eq("late_rsp_ignored", 32'(link_up), 32'd0);
        while (phy_rst_n === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge bd_fclk0_125m);
        end
        check_eq("swrst_hold_len", 32'(cnt), 32'd8);
        count_idle(cnt);
        check_eq("swrst_settle_len", 32'(cnt), 32'd4);

        init_round();

        // Stray response during POLL_IDLE must not touch link state or the timer.
        rsp_valid = 1'b1;
        rsp_rdata = 16'h0004;
        @(negedge bd_fclk0_125m);
        rsp_valid = 1'b0;
        rsp_rdata = 16'h0000;
        check_eq("idle_rsp_ignored", 32'(link_up), 32'd0);
        count_idle(cnt);
        check_eq("idle_len_stray", 32'(cnt), 32'd15);

        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                count_idle(cnt);
                check_eq("poll4_gap", 32'(cnt), 32'd0);
            end
            serve($sformatf("poll4_%0d", i), 1'b0, 5'(4 + i), 5'd1, 16'h0000, rd4[i]);
        end
        check_eq("link_round4", 32'(link_up), 32'h2);
        check_eq("final_err", 32'(timeout_err), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
